// File: rtl/hyperbus_txn_scheduler.sv
// ---------------------------------------------------------------------------
// hyperbus_txn_scheduler: read/write arbiter, CS decode and PHY segment splitter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hyperbus_txn_scheduler #(
  parameter int          NR_CS      = 2,
  parameter logic [31:0] CHIP_BYTES = 32'h0040_0000,
  parameter int          AW         = 32,
  parameter int          IW         = 10
) (
  input  logic             clk_sys_i,
  input  logic             rst_ni,
  input  logic [15:0]      cfg_max_words_i,
  input  logic             rd_valid_i,
  input  logic             wr_valid_i,
  output logic             rd_ready_o,
  output logic             wr_ready_o,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [7:0]       rd_len_i,
  input  logic [7:0]       wr_len_i,
  input  logic [IW-1:0]    rd_id_i,
  input  logic [IW-1:0]    wr_id_i,
  output logic             seg_valid_o,
  input  logic             seg_ready_i,
  output logic             seg_write_o,
  output logic             seg_reg_o,
  output logic [NR_CS-1:0] seg_cs_o,
  output logic [AW-1:0]    seg_addr_o,
  output logic [8:0]       seg_words_o,
  input  logic             seg_done_i,
  input  logic             seg_err_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_write_o,
  output logic [IW-1:0]    rsp_id_o,
  output logic [1:0]       rsp_resp_o
);

  localparam int            CHIP_SHIFT    = $clog2(CHIP_BYTES);
  localparam logic [AW-1:0] CHIP_BYTES_AW = AW'(CHIP_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              last_wr;
  logic              decode_pend;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [7:0]        req_len;
  logic [IW-1:0]     req_id;
  logic [8:0]        words_left;
  logic [AW-1:0]     cur_addr;
  logic [NR_CS-1:0]  cur_cs;

  logic              grant_wr;
  logic [8:0]        dec_words;
  logic [AW-1:0]     dec_base;
  logic [AW-1:0]     dec_end;
  logic [AW-1:0]     dec_chip;
  logic [AW-1:0]     dec_end_chip;
  logic [AW-1:0]     dec_local;
  logic [NR_CS-1:0]  dec_cs;
  logic              dec_err;
  logic [AW-1:0]     next_addr;

  // Tie goes to the direction that did not win last time.
  assign grant_wr = wr_valid_i && (!rd_valid_i || !last_wr);

  always_comb begin
    dec_words    = {1'b0, req_len} + 9'd1;
    dec_base     = req_addr[AW-1] ? {1'b0, req_addr[AW-2:0]} : req_addr;
    dec_end      = dec_base + AW'({dec_words, 1'b0}) - AW'(1);
    dec_chip     = dec_base >> CHIP_SHIFT;
    dec_end_chip = dec_end >> CHIP_SHIFT;
    dec_local    = dec_base & (CHIP_BYTES_AW - AW'(1));
    dec_cs       = NR_CS'(1) << dec_chip;
    if (req_addr[AW-1]) begin
      dec_err = (req_len != 8'd0) || (dec_chip >= AW'(NR_CS));
    end else begin
      dec_err = dec_end_chip >= AW'(NR_CS);
    end
  end

  assign next_addr = cur_addr + AW'({seg_words_o, 1'b0});

  // Segment size from registered state only; never from seg_ready_i.
  function automatic logic [8:0] seg_size(input logic [8:0]    left,
                                          input logic [AW-1:0] local_addr,
                                          input logic [15:0]   max_words);
    logic [AW-1:0] room;
    logic [8:0]    n;
    room = (CHIP_BYTES_AW - local_addr) >> 1;
    n    = left;
    if (max_words != 16'd0 && max_words < {7'd0, n}) n = max_words[8:0];
    if (room < AW'(n)) n = room[8:0];
    return n;
  endfunction

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_wr     <= 1'b1;
      decode_pend <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_len     <= '0;
      req_id      <= '0;
      words_left  <= '0;
      cur_addr    <= '0;
      cur_cs      <= '0;
      rd_ready_o  <= 1'b0;
      wr_ready_o  <= 1'b0;
      seg_valid_o <= 1'b0;
      seg_write_o <= 1'b0;
      seg_reg_o   <= 1'b0;
      seg_cs_o    <= '0;
      seg_addr_o  <= '0;
      seg_words_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_resp_o  <= 2'b00;
    end else begin
      rd_ready_o <= 1'b0;
      wr_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (decode_pend) begin
            decode_pend <= 1'b0;
            rsp_write_o <= req_write;
            rsp_id_o    <= req_id;
            if (dec_err) begin
              rsp_resp_o  <= 2'b11;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              words_left  <= dec_words;
              cur_addr    <= dec_local;
              cur_cs      <= dec_cs;
              seg_valid_o <= 1'b1;
              seg_write_o <= req_write;
              seg_reg_o   <= req_addr[AW-1];
              seg_cs_o    <= dec_cs;
              seg_addr_o  <= dec_local;
              seg_words_o <= seg_size(dec_words, dec_local, cfg_max_words_i);
              state       <= ISSUE;
            end
          end else if (rd_valid_i || wr_valid_i) begin
            req_write   <= grant_wr;
            last_wr     <= grant_wr;
            req_addr    <= grant_wr ? wr_addr_i : rd_addr_i;
            req_len     <= grant_wr ? wr_len_i : rd_len_i;
            req_id      <= grant_wr ? wr_id_i : rd_id_i;
            rd_ready_o  <= !grant_wr;
            wr_ready_o  <= grant_wr;
            decode_pend <= 1'b1;
          end
        end
        ISSUE: begin
          if (seg_ready_i) begin
            seg_valid_o <= 1'b0;
            words_left  <= words_left - seg_words_o;
            if (next_addr >= CHIP_BYTES_AW) begin
              cur_addr <= next_addr - CHIP_BYTES_AW;
              cur_cs   <= cur_cs << 1;
            end else begin
              cur_addr <= next_addr;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (seg_done_i) begin
            if (seg_err_i) begin
              rsp_resp_o  <= 2'b10;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else if (words_left == 9'd0) begin
              rsp_resp_o  <= 2'b00;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              seg_valid_o <= 1'b1;
              seg_cs_o    <= cur_cs;
              seg_addr_o  <= cur_addr;
              seg_words_o <= seg_size(words_left, cur_addr, cfg_max_words_i);
              state       <= ISSUE;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_txn_scheduler: vector table, corner sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hyperbus_txn_scheduler;

  localparam int     NR_CS = 2;
  localparam longint CHIP  = 64'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cfg_max_words = '0;
  logic        rd_valid = 1'b0, wr_valid = 1'b0;
  logic        rd_ready, wr_ready;
  logic [31:0] rd_addr = '0, wr_addr = '0;
  logic [7:0]  rd_len = '0, wr_len = '0;
  logic [9:0]  rd_id = '0, wr_id = '0;
  logic        seg_valid, seg_write, seg_reg;
  logic        seg_ready = 1'b0;
  logic [1:0]  seg_cs;
  logic [31:0] seg_addr;
  logic [8:0]  seg_words;
  logic        seg_done = 1'b0, seg_err = 1'b0;
  logic        rsp_valid, rsp_write;
  logic        rsp_ready = 1'b0;
  logic [9:0]  rsp_id;
  logic [1:0]  rsp_resp;

  hyperbus_txn_scheduler dut (
    .clk_sys_i       (clk),
    .rst_ni          (rst_n),
    .cfg_max_words_i (cfg_max_words),
    .rd_valid_i      (rd_valid),
    .wr_valid_i      (wr_valid),
    .rd_ready_o      (rd_ready),
    .wr_ready_o      (wr_ready),
    .rd_addr_i       (rd_addr),
    .wr_addr_i       (wr_addr),
    .rd_len_i        (rd_len),
    .wr_len_i        (wr_len),
    .rd_id_i         (rd_id),
    .wr_id_i         (wr_id),
    .seg_valid_o     (seg_valid),
    .seg_ready_i     (seg_ready),
    .seg_write_o     (seg_write),
    .seg_reg_o       (seg_reg),
    .seg_cs_o        (seg_cs),
    .seg_addr_o      (seg_addr),
    .seg_words_o     (seg_words),
    .seg_done_i      (seg_done),
    .seg_err_i       (seg_err),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_write_o     (rsp_write),
    .rsp_id_o        (rsp_id),
    .rsp_resp_o      (rsp_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cs;
    logic [31:0] addr;
    int          words;
    bit          reg_sp;
    bit          wr;
  } seg_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [9:0]  id;
    logic [15:0] cfg;
    int          err;
    int          nseg;
    logic [1:0]  resp;
    logic [1:0]  cs;
    logic [31:0] saddr;
    int          words;
  } vec_t;

  seg_t       exp_q[$];
  seg_t       obs_q[$];
  logic [1:0] exp_resp;
  logic [1:0] obs_resp;
  logic [9:0] obs_id;
  bit         obs_wr;
  int         lat;
  vec_t       tbl[12];
  int         checks = 0;
  int         failures = 0;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint outs();
    return {2'b00, rd_ready, wr_ready, seg_valid, seg_write, seg_reg, seg_cs, seg_addr,
            seg_words, rsp_valid, rsp_write, rsp_id, rsp_resp};
  endfunction

  // Expected segment list derived from global byte addresses and plain division.
  task automatic model(input bit wr, input logic [31:0] addr, input int len,
                       input int cfg, input int err_seg);
    longint a, left, n, room, chip, endb;
    seg_t   s;
    exp_q.delete();
    if (addr[31]) begin
      a    = longint'(addr) - 64'h8000_0000;
      chip = a / CHIP;
      if (len != 0 || chip >= NR_CS) begin
        exp_resp = 2'b11;
        return;
      end
      s = '{cs: 2'(1 << chip), addr: 32'(a % CHIP), words: 1, reg_sp: 1'b1, wr: wr};
      exp_q.push_back(s);
      exp_resp = (err_seg == 0) ? 2'b10 : 2'b00;
      return;
    end
    endb = longint'(addr) + 2 * (len + 1) - 1;
    if (endb / CHIP >= NR_CS) begin
      exp_resp = 2'b11;
      return;
    end
    a    = longint'(addr);
    left = len + 1;
    while (left > 0) begin
      chip = a / CHIP;
      room = (CHIP - (a % CHIP)) / 2;
      n    = left;
      if (cfg != 0 && cfg < n) n = cfg;
      if (room < n) n = room;
      s = '{cs: 2'(1 << chip), addr: 32'(a % CHIP), words: int'(n), reg_sp: 1'b0, wr: wr};
      exp_q.push_back(s);
      if (exp_q.size() - 1 == err_seg) begin
        exp_resp = 2'b10;
        return;
      end
      a    = a + 2 * n;
      left = left - n;
    end
    exp_resp = 2'b00;
  endtask

  task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [9:0] id);
    if (wr) begin
      wr_valid = 1'b1; wr_addr = addr; wr_len = len; wr_id = id;
    end else begin
      rd_valid = 1'b1; rd_addr = addr; rd_len = len; rd_id = id;
    end
  endtask

  task automatic wait_grant(input string tag, output bit got_wr);
    int cyc;
    cyc = 0;
    while (!rd_ready && !wr_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!rd_ready && !wr_ready) chk($sformatf("%s.grant_timeout", tag), 0, 1);
    got_wr   = wr_ready;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
  endtask

  // Acts as the PHY and the response consumer until one response is taken.
  task automatic serve(input string tag, input int err_seg);
    int   cyc;
    seg_t s;
    obs_q.delete();
    lat = -1;
    while (1) begin
      cyc = 0;
      while (!seg_valid && !rsp_valid && cyc < 64) begin
        @(negedge clk);
        cyc++;
      end
      if (!seg_valid && !rsp_valid) begin
        chk($sformatf("%s.wait_timeout", tag), 0, 1);
        return;
      end
      if (lat < 0) lat = cyc;
      if (rsp_valid) break;
      if (obs_q.size() >= 300) begin
        chk($sformatf("%s.segment_runaway", tag), obs_q.size(), 256);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s = '{cs: seg_cs, addr: seg_addr, words: int'(seg_words), reg_sp: seg_reg, wr: seg_write};
      obs_q.push_back(s);
      seg_ready = 1'b1;
      @(negedge clk);
      seg_ready = 1'b0;
      chk($sformatf("%s.seg_valid_drop", tag), seg_valid, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      seg_done = 1'b1;
      seg_err  = (int'(obs_q.size()) - 1 == err_seg);
      @(negedge clk);
      seg_done = 1'b0;
      seg_err  = 1'b0;
    end
    obs_resp = rsp_resp;
    obs_id   = rsp_id;
    obs_wr   = rsp_write;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("%s.rsp_valid_drop", tag), rsp_valid, 0);
  endtask

  task automatic compare(input string tag, input bit wr, input logic [9:0] id);
    chk($sformatf("%s.nseg", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.seg%0d.cs", tag, i), obs_q[i].cs, exp_q[i].cs);
      chk($sformatf("%s.seg%0d.addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s.seg%0d.words", tag, i), obs_q[i].words, exp_q[i].words);
      chk($sformatf("%s.seg%0d.reg", tag, i), obs_q[i].reg_sp, exp_q[i].reg_sp);
      chk($sformatf("%s.seg%0d.write", tag, i), obs_q[i].wr, exp_q[i].wr);
    end
    chk($sformatf("%s.resp", tag), obs_resp, exp_resp);
    chk($sformatf("%s.rsp_id", tag), obs_id, id);
    chk($sformatf("%s.rsp_write", tag), obs_wr, wr);
  endtask

  task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [7:0] len, input logic [9:0] id,
                         input logic [15:0] cfg, input int err_seg);
    bit got_wr;
    model(wr, addr, int'(len), int'(cfg), err_seg);
    cfg_max_words = cfg;
    drive_req(wr, addr, len, id);
    wait_grant(tag, got_wr);
    chk($sformatf("%s.grant_dir", tag), got_wr, wr);
    serve(tag, err_seg);
    compare(tag, wr, id);
  endtask

  initial begin
    bit          got_wr;
    bit          tie_wr;
    int          cyc;
    int          sel;
    bit          rw;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [15:0] rc;
    int          re;

    tbl[0]  = '{1'b1, 32'h0000_0010, 8'd15, 10'h012, 16'd0, -1, 1, 2'b00, 2'b01, 32'h0000_0010, 16};
    tbl[1]  = '{1'b0, 32'h0000_0000, 8'd15, 10'h02A, 16'd5, -1, 4, 2'b00, 2'b01, 32'h0000_0000, 5};
    tbl[2]  = '{1'b1, 32'h003F_FFFE, 8'd1,  10'h033, 16'd0, -1, 2, 2'b00, 2'b01, 32'h003F_FFFE, 1};
    tbl[3]  = '{1'b0, 32'h0090_0000, 8'd0,  10'h044, 16'd0, -1, 0, 2'b11, 2'b00, 32'h0, 0};
    tbl[4]  = '{1'b0, 32'h8000_0800, 8'd3,  10'h055, 16'd0, -1, 0, 2'b11, 2'b00, 32'h0, 0};
    tbl[5]  = '{1'b0, 32'h8000_0800, 8'd0,  10'h066, 16'd0, -1, 1, 2'b00, 2'b01, 32'h0000_0800, 1};
    tbl[6]  = '{1'b1, 32'h0000_0100, 8'd15, 10'h077, 16'd8,  0, 1, 2'b10, 2'b01, 32'h0000_0100, 8};
    tbl[7]  = '{1'b0, 32'h0040_0010, 8'd3,  10'h088, 16'd0, -1, 1, 2'b00, 2'b10, 32'h0000_0010, 4};
    tbl[8]  = '{1'b1, 32'h007F_FFFC, 8'd1,  10'h099, 16'd0, -1, 1, 2'b00, 2'b10, 32'h003F_FFFC, 2};
    tbl[9]  = '{1'b1, 32'h007F_FFFE, 8'd1,  10'h0AA, 16'd0, -1, 0, 2'b11, 2'b00, 32'h0, 0};
    tbl[10] = '{1'b0, 32'h8040_0000, 8'd0,  10'h0BB, 16'd0, -1, 1, 2'b00, 2'b10, 32'h0000_0000, 1};
    tbl[11] = '{1'b0, 32'h8080_0000, 8'd0,  10'h0CC, 16'd0, -1, 0, 2'b11, 2'b00, 32'h0, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].id,
              tbl[i].cfg, tbl[i].err);
      chk($sformatf("vec%0d.tbl_nseg", i), obs_q.size(), tbl[i].nseg);
      chk($sformatf("vec%0d.tbl_resp", i), obs_resp, tbl[i].resp);
      chk($sformatf("vec%0d.latency", i), lat, 1);
      if (tbl[i].nseg > 0) begin
        chk($sformatf("vec%0d.tbl_cs", i), obs_q[0].cs, tbl[i].cs);
        chk($sformatf("vec%0d.tbl_addr", i), obs_q[0].addr, tbl[i].saddr);
        chk($sformatf("vec%0d.tbl_words", i), obs_q[0].words, tbl[i].words);
      end
    end

    // Reset while a segment is outstanding.
    cfg_max_words = 16'd8;
    drive_req(1'b1, 32'h0000_0200, 8'd15, 10'h155);
    wait_grant("rst", got_wr);
    cyc = 0;
    while (!seg_valid && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst.seg_valid", seg_valid, 1);
    seg_ready = 1'b1;
    @(negedge clk);
    seg_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst.async_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests: alternation starts with read after reset.
    for (int k = 0; k < 4; k++) begin
      cfg_max_words = 16'd0;
      drive_req(1'b0, 32'h0000_0020 * k, 8'd1, 10'(10'h100 + k));
      drive_req(1'b1, 32'h0000_1000, 8'd0, 10'(10'h200 + k));
      wait_grant($sformatf("tie%0d", k), got_wr);
      tie_wr = (k % 2 == 1);
      chk($sformatf("tie%0d.grant_dir", k), got_wr, tie_wr);
      if (got_wr) model(1'b1, 32'h0000_1000, 0, 0, -1);
      else        model(1'b0, 32'h0000_0020 * k, 1, 0, -1);
      serve($sformatf("tie%0d", k), -1);
      compare($sformatf("tie%0d", k), got_wr, got_wr ? 10'(10'h200 + k) : 10'(10'h100 + k));
    end

    for (int t = 0; t < 40; t++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      rl  = 8'($urandom_range(0, 255));
      if (sel < 5) begin
        ra = 32'($urandom_range(0, 32'h007F_FFFF)) & 32'hFFFF_FFFE;
      end else if (sel < 8) begin
        ra = 32'h003F_FE00 + 32'($urandom_range(0, 511)) * 2;
      end else if (sel < 9) begin
        ra = (32'h8000_0000 | 32'($urandom_range(0, 32'h009F_FFFF))) & 32'hFFFF_FFFE;
        rl = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      end else begin
        ra = 32'($urandom_range(32'h0080_0000, 32'h00FF_FFFF)) & 32'hFFFF_FFFE;
      end
      rc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      re = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn($sformatf("rnd%0d", t), rw, ra, rl, 10'($urandom_range(0, 1023)), rc, re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
